// File: rtl/monkey_hit_detector.sv
// Per-frame monkey/player collision debouncer and monkey-edge border summary.
// Define MONKEY_HIT_COUNT_EN to compile in the saturating hitCount counter.
module monkey_hit_detector #(
  parameter int MIN_OVERLAP_PIXELS = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       monkeyDrawingRequest,
  input  logic [3:0] monkeyHitEdgeCode,
  input  logic       playerDrawingRequest,
  input  logic       borderDrawingRequest,
  output logic       collisionPlayer,
  output logic [3:0] borderEdgeMask,
  output logic       borderHitValid,
  output logic [7:0] hitCount
);

  typedef enum logic [1:0] {WAIT_SOF, ARMED, FIRED} state_t;

  localparam logic [7:0] MIN_CNT = 8'(MIN_OVERLAP_PIXELS);

  state_t     state_q;
  logic [7:0] overlap_cnt_q;
  logic [3:0] edge_acc_q;
  logic [3:0] border_mask_q;
  logic       border_vld_q;
  logic       coll_q;
  logic       player_overlap;
  logic       border_overlap;
  logic       fire_d;

  assign player_overlap = monkeyDrawingRequest & playerDrawingRequest;
  assign border_overlap = monkeyDrawingRequest & borderDrawingRequest;

  // A frame start restarts the count, so only a single-pixel threshold can fire on it.
  always_comb begin
    fire_d = 1'b0;
    if (state_q != WAIT_SOF && player_overlap) begin
      if (startOfFrame)
        fire_d = (MIN_CNT == 8'd1);
      else if (state_q == ARMED)
        fire_d = (overlap_cnt_q + 8'd1 >= MIN_CNT);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= WAIT_SOF;
      overlap_cnt_q <= 8'd0;
      edge_acc_q    <= 4'h0;
      border_mask_q <= 4'h0;
      border_vld_q  <= 1'b0;
      coll_q        <= 1'b0;
    end else begin
      coll_q       <= fire_d;
      border_vld_q <= 1'b0;
      if (state_q == WAIT_SOF) begin
        if (startOfFrame)
          state_q <= ARMED;
      end else if (startOfFrame) begin
        overlap_cnt_q <= {7'd0, player_overlap};
        border_mask_q <= edge_acc_q;
        border_vld_q  <= |edge_acc_q;
        edge_acc_q    <= border_overlap ? monkeyHitEdgeCode : 4'h0;
        state_q       <= fire_d ? FIRED : ARMED;
      end else begin
        if (border_overlap)
          edge_acc_q <= edge_acc_q | monkeyHitEdgeCode;
        if (state_q == ARMED && player_overlap) begin
          if (fire_d) begin
            overlap_cnt_q <= MIN_CNT;
            state_q       <= FIRED;
          end else begin
            overlap_cnt_q <= overlap_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign collisionPlayer = coll_q;
  assign borderEdgeMask  = border_mask_q;
  assign borderHitValid  = border_vld_q;

`ifdef MONKEY_HIT_COUNT_EN
  logic [7:0] hit_cnt_q;
  logic [7:0] hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (fire_d && hit_cnt_q != 8'hFF)
      hit_cnt_d = hit_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      hit_cnt_q <= 8'h00;
    else
      hit_cnt_q <= hit_cnt_d;
  end

  assign hitCount = hit_cnt_q;
`else
  assign hitCount = 8'h00;
`endif

endmodule
